// File: rtl/nor3_sweep_ctrl_if.sv
// Control and gate-side bus of the NOR3 sweep sequencer.
//   start/abort   : sweep requests from the lab top
//   busy/done/pass, err_cnt, fail_vec : sweep status and results
//   a,b,c         : vector driven to the gate under test
//   d,e           : gate outputs fed back for checking
// slave  = the sequencer, master = whoever drives start/abort and hosts the gate.
interface nor3_sweep_ctrl_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        err_cnt;
   logic [2**N_IN-1:0]   fail_vec;
   logic                 a, b, c;
   logic                 d, e;

   modport slave (
      input  start, abort, d, e,
      output busy, done, pass, err_cnt, fail_vec, a, b, c
   );

   modport master (
      output start, abort, d, e,
      input  busy, done, pass, err_cnt, fail_vec, a, b, c
   );
endinterface

// File: rtl/nor3_sweep_ctrl.sv
// Sweep sequencer for a three-input NOR gate datapath.
// On start, walks {a,b,c} through 0..2**N_IN-1 (c = LSB). Each vector is held
// SETTLE cycles, then d/e are sampled for one cycle and compared against the
// EXP_D/EXP_E truth tables. Reports busy/done/pass, a mismatch count and a
// per-vector fail map.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of nor3_sweep_ctrl_if (start/abort in, status out,
//          a,b,c out to the gate, d,e back from it)
module nor3_sweep_ctrl #(
   parameter int                  N_IN   = 3,
   parameter int                  SETTLE = 2,
   parameter logic [2**N_IN-1:0]  EXP_D  = 8'b00000001,
   parameter logic [2**N_IN-1:0]  EXP_E  = 8'b11111110
) (
   input  logic                  clk,
   input  logic                  rst,
   nor3_sweep_ctrl_if.slave      bus
);
   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE
   } state_t;

   state_t            state_q, state_n;
   logic [N_IN-1:0]   vec_q, vec_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              pass_q, pass_n;
   logic [N_IN:0]     err_q, err_n;
   logic [NV-1:0]     fail_q, fail_n;
   logic              mismatch;

   // Both outputs wrong on one vector still counts as a single failing vector.
   assign mismatch = (bus.d != EXP_D[vec_q]) | (bus.e != EXP_E[vec_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_n;
         vec_q   <= vec_n;
         cnt_q   <= cnt_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         pass_q  <= pass_n;
         err_q   <= err_n;
         fail_q  <= fail_n;
      end
   end

   always_comb begin
      state_n = state_q;
      vec_n   = vec_q;
      cnt_n   = cnt_q;
      busy_n  = busy_q;
      done_n  = done_q;
      pass_n  = pass_q;
      err_n   = err_q;
      fail_n  = fail_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_n = S_SETTLE;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               pass_n  = 1'b0;
               err_n   = '0;
               fail_n  = '0;
               vec_n   = '0;
               cnt_n   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               cnt_n   = '0;
               state_n = S_SAMPLE;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               if (err_q != (N_IN+1)'(NV))
                  err_n = err_q + 1'b1;
               fail_n[vec_q] = 1'b1;
            end
            if (vec_q == N_IN'(NV - 1)) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               pass_n  = (err_n == '0);   // includes this last sample
               vec_n   = '0;
            end else begin
               vec_n   = vec_q + 1'b1;
               state_n = S_SETTLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Abort overrides any sweep step, including the final sample: the sample
      // of this cycle is dropped and results keep what was gathered so far.
      if (bus.abort && state_q != S_IDLE) begin
         state_n = S_IDLE;
         busy_n  = 1'b0;
         done_n  = 1'b0;
         pass_n  = 1'b0;
         vec_n   = '0;
         cnt_n   = '0;
         err_n   = err_q;
         fail_n  = fail_q;
      end
   end

   // The gate has exactly three inputs; the vector index maps onto them.
   assign {bus.a, bus.b, bus.c} = 3'(vec_q);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.err_cnt  = err_q;
   assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_nor3_sweep_ctrl.sv
// Bench for nor3_sweep_ctrl. A fault-injectable NOR/OR gate model hangs off
// a,b,c; every sweep pushes its expected outcome into a queue, and a monitor
// pops it whenever busy falls.
module tb_nor3_sweep_ctrl;
   localparam int N_IN   = 3;
   localparam int SETTLE = 2;
   localparam int NV     = 8;
   localparam int PER    = SETTLE + 1;
   localparam int FULL   = NV * PER;

   typedef struct {
      int lat;
      int err;
      int fail;
      int done;
      int pass;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nor3_sweep_ctrl_if #(.N_IN(N_IN)) bus();

   nor3_sweep_ctrl #(
      .N_IN(N_IN), .SETTLE(SETTLE),
      .EXP_D(8'b00000001), .EXP_E(8'b11111110)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Gate model: ideal NOR/OR with per-vector flip masks as injected faults.
   logic [7:0] dm, em;
   logic [2:0] gv;
   assign gv    = {bus.a, bus.b, bus.c};
   assign bus.d = ~(|gv) ^ dm[gv];
   assign bus.e =  (|gv) ^ em[gv];

   int   total = 0;
   int   bad   = 0;
   exp_t sbq[$];
   int   last_err, last_fail;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outcome: the first nsamp vectors are judged; a vector fails if
   // either of its outputs was flipped.
   task automatic push_exp(input int lat, input int nsamp, input int is_done);
      exp_t x;
      x.lat = lat; x.err = 0; x.fail = 0;
      for (int v = 0; v < nsamp; v++)
         if (dm[v] || em[v]) begin
            x.err++;
            x.fail |= (1 << v);
         end
      x.done = is_done;
      x.pass = (is_done != 0 && x.err == 0) ? 1 : 0;
      last_err  = x.err;
      last_fail = x.fail;
      sbq.push_back(x);
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_to_end(input bit rnd_start);
      int n;
      n = 0;
      while (bus.busy && n < 4 * FULL) begin
         bus.start = rnd_start ? ($urandom_range(0, 2) == 0) : 1'b0;
         tick();
         n++;
      end
      bus.start = 1'b0;
      if (bus.busy) begin
         total++; bad++;
         $display("FAIL sweep_timeout: busy still %0d after %0d cycles", bus.busy, n);
      end
   endtask

   task automatic check_hold(input string nm, input int dn);
      repeat (3) begin
         bus.abort = $urandom_range(0, 1);
         tick();
      end
      bus.abort = 1'b0;
      chk({nm, "_busy"}, int'(bus.busy), 0);
      chk({nm, "_done"}, int'(bus.done), dn);
      chk({nm, "_err"},  int'(bus.err_cnt), last_err);
      chk({nm, "_fail"}, int'(bus.fail_vec), last_fail);
   endtask

   task automatic full_sweep(input string nm, input bit rnd_start);
      push_exp(FULL, NV, 1);
      start_pulse();
      run_to_end(rnd_start);
      check_hold(nm, 1);
   endtask

   task automatic abort_at(input string nm, input int k);
      push_exp(k, (k - 1) / PER, 0);
      start_pulse();
      repeat (k - 1) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk({nm, "_abc"}, int'(gv), 0);
      check_hold(nm, 0);
   endtask

   // Monitor: per-cycle vector stepping while busy; scoreboard pop on busy fall.
   initial begin
      int   bcnt;
      logic pb;
      exp_t x;
      bcnt = 0;
      pb   = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.busy === 1'b1) begin
            if (bcnt % PER == 0) chk("abc_step", int'(gv), bcnt / PER);
            bcnt++;
         end else if (pb === 1'b1) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_underflow: sweep ended with no expected entry");
            end else begin
               x = sbq.pop_front();
               chk("sb_latency", bcnt, x.lat);
               chk("sb_done",    int'(bus.done), x.done);
               chk("sb_pass",    int'(bus.pass), x.pass);
               chk("sb_err_cnt", int'(bus.err_cnt), x.err);
               chk("sb_fail_vec", int'(bus.fail_vec), x.fail);
               chk("sb_abc_idle", int'(gv), 0);
            end
            bcnt = 0;
         end
         pb = bus.busy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
      dm = 8'h00; em = 8'h00;
      repeat (2) tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_err",  int'(bus.err_cnt), 0);
      chk("rst_fail", int'(bus.fail_vec), 0);
      chk("rst_abc",  int'(gv), 0);
      rst = 1'b0;
      tick();

      // ideal gate
      full_sweep("ideal", 1'b0);
      chk("ideal_pass", int'(bus.pass), 1);
      // d stuck-at-0: only vector 0 has d=1
      dm = 8'h01; full_sweep("d_sa0", 1'b0);
      chk("d_sa0_pass", int'(bus.pass), 0);
      // e wrong only at abc=101, then e stuck-at-1 on a fresh sweep
      dm = 8'h00; em = 8'h20; full_sweep("e_101", 1'b0);
      em = 8'h01; full_sweep("e_sa1", 1'b1);

      // start held high through a sweep, then restarts straight from done
      dm = 8'h00; em = 8'h00;
      push_exp(FULL, NV, 1);
      push_exp(FULL, NV, 1);
      bus.start = 1'b1;
      tick();
      k = 0;
      while (bus.busy && k < 4 * FULL) begin tick(); k++; end
      chk("held_done", int'(bus.done), 1);
      tick();
      bus.start = 1'b0;
      chk("held_restart_busy", int'(bus.busy), 1);
      chk("held_restart_done", int'(bus.done), 0);
      run_to_end(1'b0);

      // aborts: mid-sweep, first cycle, and same cycle as final sample
      dm = 8'h0B; em = 8'h90;
      abort_at("abort10", 10);
      abort_at("abort1", 1);
      abort_at("abort_last", FULL);

      // reset mid-sweep, then a normal sweep
      push_exp(13, 0, 0);
      start_pulse();
      repeat (12) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_err",  int'(bus.err_cnt), 0);
      chk("mrst_fail", int'(bus.fail_vec), 0);
      chk("mrst_done", int'(bus.done), 0);
      full_sweep("post_rst", 1'b0);

      // randomized sweeps
      for (int i = 0; i < 10; i++) begin
         dm = 8'($urandom & $urandom);
         em = 8'($urandom & $urandom);
         if ($urandom_range(0, 3) == 0) begin dm = 8'h00; em = 8'h00; end
         if ($urandom_range(0, 2) == 0)
            abort_at("rnd_abort", int'($urandom_range(1, FULL)));
         else
            full_sweep("rnd_full", $urandom_range(0, 1) == 1);
      end

      repeat (3) tick();
      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
